// File: rtl/tlb_pkg.sv
// tlb_pkg: shared walker state encoding and PTE field layout for the STLB page-table walker.
package tlb_pkg;
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} walk_state_e;
    localparam int PTE_PRESENT  = 0;
    localparam int PTE_FRAME_LO = 12;
    localparam int PTE_FRAME_HI = 63;
    localparam int LVL_W        = 2;
endpackage

// File: rtl/stlb_walker_addr.sv
// stlb_walker_addr: physical address of the PTE selected by va at the given table level.
module stlb_walker_addr
    import tlb_pkg::*;
#(
    parameter int SADDR = 64,
    parameter int SPAGE = 12,
    parameter int SIDX  = 9
) (
    input  logic [SADDR-SPAGE-1:0] base_i,
    input  logic [SADDR-1:0]       va_i,
    input  logic [LVL_W-1:0]       lvl_i,
    output logic [SADDR-1:0]       addr_o
);
    logic [SADDR-1:0] sh;
    assign sh     = va_i >> (SPAGE + SIDX * int'(lvl_i));
    assign addr_o = {base_i, sh[SIDX-1:0], 3'b000};
endmodule

// File: rtl/stlb_walker.sv
// stlb_walker: single-outstanding 4-level radix page-table walker feeding STLB inserts.
module stlb_walker
    import tlb_pkg::*;
#(
    parameter int SADDR  = 64,
    parameter int SPAGE  = 12,
    parameter int SPCID  = 12,
    parameter int NLEVEL = 4,
    parameter int SIDX   = 9,
    parameter int SPTE   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shutdown,
    input  logic [SADDR-1:0] root_base,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SADDR-1:0] req_va,
    input  logic [SPCID-1:0] req_pcid,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [SADDR-1:0] mem_addr,
    input  logic             mem_resp_valid,
    input  logic [SPTE-1:0]  mem_resp_data,
    output logic             done,
    output logic             insert,
    output logic             fault,
    output logic [SADDR-1:0] out_va,
    output logic [SPCID-1:0] out_pcid,
    output logic [SADDR-1:0] out_pa
);
    walk_state_e           state_q, state_d;
    logic [SADDR-1:0]      va_q, va_d, pa_q, pa_d, addr;
    logic [SPCID-1:0]      pcid_q, pcid_d;
    logic [SADDR-SPAGE-1:0] base_q, base_d;
    logic [LVL_W-1:0]      lvl_q, lvl_d;
    logic                  flt_q, flt_d;
    logic                  unused_bits;

    stlb_walker_addr #(.SADDR(SADDR), .SPAGE(SPAGE), .SIDX(SIDX)) u_addr (
        .base_i(base_q),
        .va_i  (va_q),
        .lvl_i (lvl_q),
        .addr_o(addr)
    );

    assign req_ready     = state_q == S_IDLE && !shutdown;
    assign mem_req_valid = state_q == S_REQ;
    assign mem_addr      = mem_req_valid ? addr : '0;
    assign done          = state_q == S_DONE;
    assign insert        = done && !flt_q;
    assign fault         = done && flt_q;
    assign out_va        = va_q;
    assign out_pcid      = pcid_q;
    assign out_pa        = pa_q;
    assign unused_bits   = ^{root_base[SPAGE-1:0], mem_resp_data[PTE_FRAME_LO-1:PTE_PRESENT+1]};

    always_comb begin
        state_d = state_q;
        va_d    = va_q;
        pcid_d  = pcid_q;
        base_d  = base_q;
        lvl_d   = lvl_q;
        pa_d    = pa_q;
        flt_d   = flt_q;
        case (state_q)
            S_IDLE: if (req_valid && !shutdown) begin
                va_d    = req_va;
                pcid_d  = req_pcid;
                base_d  = root_base[SADDR-1:SPAGE];
                lvl_d   = LVL_W'(NLEVEL - 1);
                pa_d    = '0;
                flt_d   = 1'b0;
                state_d = S_REQ;
            end
            // a handshake that coincides with shutdown still owes us a response
            S_REQ: state_d = shutdown ? (mem_req_ready ? S_DRAIN : S_IDLE)
                                      : (mem_req_ready ? S_WAIT : S_REQ);
            S_WAIT: if (mem_resp_valid) begin
                if (shutdown) state_d = S_IDLE;
                else if (!mem_resp_data[PTE_PRESENT]) begin
                    flt_d   = 1'b1;
                    state_d = S_DONE;
                end else if (lvl_q != '0) begin
                    base_d  = mem_resp_data[PTE_FRAME_HI:PTE_FRAME_LO];
                    lvl_d   = lvl_q - 1'b1;
                    state_d = S_REQ;
                end else begin
                    pa_d    = {mem_resp_data[PTE_FRAME_HI:PTE_FRAME_LO], va_q[SPAGE-1:0]};
                    state_d = S_DONE;
                end
            end else if (shutdown) state_d = S_DRAIN;
            S_DONE:  state_d = S_IDLE;
            S_DRAIN: state_d = mem_resp_valid ? S_IDLE : S_DRAIN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            va_q    <= '0;
            pcid_q  <= '0;
            base_q  <= '0;
            lvl_q   <= '0;
            pa_q    <= '0;
            flt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            va_q    <= va_d;
            pcid_q  <= pcid_d;
            base_q  <= base_d;
            lvl_q   <= lvl_d;
            pa_q    <= pa_d;
            flt_q   <= flt_d;
        end
    end
endmodule
